// File: rtl/wta_disparity.sv
// wta_disparity: winner-take-all disparity selection over a serial stream of census costs.
// Tracks best and second-best cost per pixel and publishes them with a uniqueness flag.
module wta_disparity #(
    parameter int COST_WIDTH  = 5,
    parameter int NUM_DISP    = 16,
    parameter int DISP_WIDTH  = 4,
    parameter int UNIQ_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cost_valid,
    input  logic [COST_WIDTH-1:0] cost_in,
    input  logic                  pixel_clear,
    output logic                  disp_valid,
    output logic [DISP_WIDTH-1:0] disp_out,
    output logic [COST_WIDTH-1:0] min_cost,
    output logic [COST_WIDTH-1:0] second_cost,
    output logic                  confident
);
    localparam logic [DISP_WIDTH-1:0] LAST = DISP_WIDTH'(NUM_DISP - 1);
    localparam logic [COST_WIDTH-1:0] MARGIN = COST_WIDTH'(UNIQ_MARGIN);

    logic [DISP_WIDTH-1:0] idx, best_idx, nxt_best_idx;
    logic [COST_WIDTH-1:0] best, second, nxt_best, nxt_second;
    logic                  accept, first, better, runner_up, done;

    assign accept    = cost_valid && !pixel_clear;
    assign first     = idx == '0;
    assign better    = cost_in < best;
    assign runner_up = cost_in < second;
    assign done      = accept && idx == LAST;

    // Index 0 restarts the search, so stale best/second never leak between pixels.
    always_comb begin
        nxt_best     = first ? cost_in : (better ? cost_in : best);
        nxt_best_idx = first ? '0 : (better ? idx : best_idx);
        nxt_second   = first ? '1 : (better ? best : (runner_up ? cost_in : second));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            best        <= '0;
            second      <= '0;
            best_idx    <= '0;
            disp_valid  <= 1'b0;
            disp_out    <= '0;
            min_cost    <= '0;
            second_cost <= '0;
            confident   <= 1'b0;
        end else begin
            disp_valid <= done;
            if (pixel_clear) begin
                idx <= '0;
            end else if (accept) begin
                idx      <= done ? '0 : idx + 1'b1;
                best     <= nxt_best;
                second   <= nxt_second;
                best_idx <= nxt_best_idx;
            end
            if (done) begin
                disp_out    <= nxt_best_idx;
                min_cost    <= nxt_best;
                second_cost <= nxt_second;
                confident   <= (nxt_second - nxt_best) >= MARGIN;
            end
        end
    end
endmodule

// File: tb/tb_wta_disparity.sv
// tb_wta_disparity: randomized and directed checks of wta_disparity against a sorting reference model.
module tb_wta_disparity;
    localparam int CW = 5, ND = 16, DW = 4, UM = 2;

    logic          clk = 1'b0, reset = 1'b0, cost_valid = 1'b0, pixel_clear = 1'b0;
    logic [CW-1:0] cost_in = '0;
    logic          disp_valid, confident;
    logic [DW-1:0] disp_out;
    logic [CW-1:0] min_cost, second_cost;

    wta_disparity #(.COST_WIDTH(CW), .NUM_DISP(ND), .DISP_WIDTH(DW), .UNIQ_MARGIN(UM)) dut (
        .clk(clk), .reset(reset), .cost_valid(cost_valid), .cost_in(cost_in),
        .pixel_clear(pixel_clear), .disp_valid(disp_valid), .disp_out(disp_out),
        .min_cost(min_cost), .second_cost(second_cost), .confident(confident)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0, cyc = 0, last_pulse = -100, gap = 0;
    int q[$];
    int e_disp = 0, e_min = 0, e_sec = 0, e_conf = 0;
    bit pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Best = smallest value (lowest index on ties); second = next element of the sorted multiset.
    task automatic resolve();
        int s[$];
        s = q;
        s.sort();
        e_min  = s[0];
        e_sec  = s[1];
        e_disp = -1;
        foreach (q[i]) if (e_disp < 0 && q[i] == e_min) e_disp = i;
        e_conf = (e_sec - e_min) >= UM;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "disp_out"}, 32'(disp_out), e_disp);
        check({pfx, "min_cost"}, 32'(min_cost), e_min);
        check({pfx, "second_cost"}, 32'(second_cost), e_sec);
        check({pfx, "confident"}, 32'(confident), e_conf);
    endtask

    task automatic step(input bit v, input int c, input bit clr);
        cost_valid  = v;
        cost_in     = CW'(c);
        pixel_clear = clr;
        pend        = 0;
        if (clr) q.delete();
        else if (v) begin
            q.push_back(c);
            if (q.size() == ND) begin
                resolve();
                pend = 1;
                q.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("disp_valid", 32'(disp_valid), 32'(pend));
        if (disp_valid) begin
            gap = cyc - last_pulse;
            last_pulse = cyc;
        end
        check_outputs("");
    endtask

    task automatic check_zero(input string tag);
        e_disp = 0; e_min = 0; e_sec = 0; e_conf = 0;
        check({tag, "_valid"}, 32'(disp_valid), 0);
        check_outputs({tag, "_"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        cost_valid  = $urandom_range(0, 1);
        cost_in     = CW'($urandom_range(0, 31));
        pixel_clear = 1'b0;
        reset       = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        q.delete();
        @(negedge clk);
        cost_valid = 1'b0;
        reset      = 1'b1;
    endtask

    initial begin
        #1;
        check_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int d = 0; d < ND; d++) step(1, 20 - d, 0);
        step(0, 0, 0);

        for (int d = 0; d < ND; d++) step(1, 7, 0);
        step(0, 0, 0);

        for (int d = 0; d < ND; d++) begin
            step(1, d == 9 ? 0 : 20, 0);
            if (d == 3 || d == 12) begin
                step(0, 0, 0);
                step(0, 0, 0);
            end
        end
        repeat (3) step(0, 0, 0);

        for (int d = 0; d < 6; d++) step(1, $urandom_range(0, 20), 0);
        step(0, 0, 1);
        for (int d = 0; d < ND; d++) step(1, d == 2 ? 3 : $urandom_range(4, 20), 0);
        step(0, 0, 0);

        for (int p = 0; p < 2; p++)
            for (int d = 0; d < ND; d++) step(1, d == (p ? 11 : 4) ? 1 : $urandom_range(2, 20), 0);
        check("b2b_gap", 32'(gap), 16);
        check("b2b_disp", 32'(disp_out), 11);
        step(1, 9, 1);
        step(0, 0, 0);

        for (int d = 0; d < 10; d++) step(1, $urandom_range(0, 20), 0);
        do_reset();
        for (int d = 0; d < ND; d++) step(1, $urandom_range(0, 20), 0);
        repeat (3) step(0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 700) == 0) do_reset();
            step($urandom_range(0, 4) != 0, $urandom_range(0, 31), $urandom_range(0, 80) == 0);
        end
        repeat (2) step(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/wta_disparity.md
WTA_DISPARITY -- requirements
Module: wta_disparity

Interface
REQ-001 Parameter COST_WIDTH, default 5, is the width of one Hamming cost, covering 0..20 for a 20-bit census window.
REQ-002 Parameter NUM_DISP, default 16, is the number of disparity candidates per pixel, with a minimum of 2.
REQ-003 Parameter DISP_WIDTH, default 4, is the disparity index width, and 2^DISP_WIDTH SHALL be at least NUM_DISP.
REQ-004 Parameter UNIQ_MARGIN, default 2, is the minimum required gap between the second-best and best cost for a match to count as confident.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port cost_valid, input, 1 bit: qualifies cost_in in the current cycle.
REQ-008 Port cost_in, input, COST_WIDTH bits: the registered Hamming count from the upstream popcount stage.
REQ-009 Port pixel_clear, input, 1 bit: synchronous abort of the pixel currently being accumulated.
REQ-010 Port disp_valid, output, 1 bit: single-cycle pulse marking a new result.
REQ-011 Port disp_out, output, DISP_WIDTH bits: disparity index of the minimum cost.
REQ-012 Port min_cost, output, COST_WIDTH bits: the best cost.
REQ-013 Port second_cost, output, COST_WIDTH bits: the second-best cost.
REQ-014 Port confident, output, 1 bit: set when (second_cost - min_cost) >= UNIQ_MARGIN.

Function
REQ-015 Costs SHALL be taken as arriving in disparity order 0..NUM_DISP-1, one per cycle with cost_valid=1; cycles with cost_valid=0 are gaps, consume nothing, and are allowed anywhere.
REQ-016 An internal index counter SHALL advance by 1 on each accepted cost and wrap to 0 after accepting index NUM_DISP-1.
REQ-017 On accepting index 0: best=cost_in, best_idx=0, second=all-ones.
REQ-018 On accepting index k>0 with cost_in < best (strict): second=best, best=cost_in, best_idx=k.
REQ-019 On accepting index k>0 with cost_in >= best and cost_in < second: second=cost_in, best unchanged.
REQ-020 Ties SHALL resolve to the lowest disparity index; an equal cost therefore updates second only.
REQ-021 Latency: if index NUM_DISP-1 is accepted in cycle N, disp_valid=1 in cycle N+1 with all result outputs valid.
REQ-022 disp_valid SHALL be high for exactly one cycle per completed pixel.
REQ-023 disp_out, min_cost, second_cost and confident SHALL hold their values until the next completed pixel.
REQ-024 The subtraction for confident SHALL be unsigned with second >= best guaranteed, so no wrap occurs.
REQ-025 Back-to-back pixels (index 0 of the next pixel accepted in cycle N+1) SHALL be sustained at full rate with no bubble.
REQ-026 pixel_clear=1 SHALL reset the index counter to 0 and discard the partial minimum.
REQ-027 pixel_clear SHALL NOT change the result outputs and SHALL suppress any disp_valid for the discarded pixel.
REQ-028 If pixel_clear and cost_valid are both high in the same cycle, pixel_clear SHALL win and cost_in is dropped.
REQ-029 A pixel_clear in the same cycle as disp_valid SHALL leave that pulse and its outputs intact.
REQ-030 The design SHALL have no backpressure; the downstream consumer must capture results on disp_valid.

Reset
REQ-031 While reset=0: disp_valid=0, disp_out=0, min_cost=0, second_cost=0, confident=0, index counter=0, best/second internal state=0.
REQ-032 A reset asserted mid-pixel SHALL discard the partial pixel, and no disp_valid SHALL occur for it after release.
REQ-033 After reset release, the first accepted cost SHALL be treated as index 0.

Verification
REQ-034 Costs 20,19,...,5 for d=0..15, contiguous -> one cycle after the last cost: disp_valid=1, disp_out=15, min_cost=5, second_cost=6, confident=0.
REQ-035 All 16 costs =7 -> disp_out=0, min_cost=7, second_cost=7, confident=0 (tie rule).
REQ-036 Cost 0 at d=9 and 20 elsewhere, with cost_valid gaps after d=3 and d=12 -> disp_out=9, min_cost=0, second_cost=20, confident=1; exactly one disp_valid pulse.
REQ-037 pixel_clear after 6 costs, then a full pixel with minimum 3 at d=2 -> a single disp_valid, disp_out=2, min_cost=3, and earlier outputs unchanged until then.
REQ-038 Two pixels back-to-back (minima at d=4 then d=11) -> disp_valid pulses exactly 16 cycles apart with disp_out 4 then 11.
REQ-039 reset=0 pulsed after 10 costs, then a full pixel -> all outputs 0 during reset, then only one valid result, for the post-reset pixel.
